// File: rtl/car_pkg.sv
// Shared constants for the car display path: BCD digit geometry and
// the default clock-derived dividers for mileage and indicator timing.
package car_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  localparam int CLK_FREQ = 100_000_000;
  // One mileage unit per second of motion, 1 Hz indicator blink.
  localparam int TICK_DIV_DEF  = CLK_FREQ;
  localparam int BLINK_DIV_DEF = CLK_FREQ / 2;

endpackage

// File: rtl/bcd_digit.sv
// One decimal odometer digit with ripple carry out.
// Ports: clk, rst (async high), clr (sync clear), inc, q[3:0], carry.
module bcd_digit
  import car_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] r_q;

  // Carry is combinational so a whole 9..9 chain rolls on one edge.
  assign carry = inc & (r_q == BCD_MAX);
  assign q     = r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? '0 : r_q + BCD_W'(1);
    end
  end

endmodule

// File: rtl/mileage_counter.sv
// BCD odometer and turn-indicator driver fed by the manual-driving stage.
// Ports: clk, rst, enable, clear, move_*, turn_*; outputs mileage_bcd,
// overflow, moving, left_led, right_led (all registered).
module mileage_counter
  import car_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int BLINK_DIV = BLINK_DIV_DEF,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  move_forward,
  input  logic                  move_backward,
  input  logic                  turn_left,
  input  logic                  turn_right,
  output logic [BCD_W*DIGITS-1:0] mileage_bcd,
  output logic                  overflow,
  output logic                  moving,
  output logic                  left_led,
  output logic                  right_led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

  logic [PW-1:0]   r_presc;
  logic [BW-1:0]   r_blink;
  logic            r_phase;
  logic            r_overflow;
  logic            r_moving;
  logic            r_left;
  logic            r_right;
  logic            w_count_en;
  logic            w_tick;
  logic            w_ind_active;
  logic [DIGITS:0] w_carry;

  // Both directions at once is an invalid request: no distance.
  assign w_count_en   = enable & (move_forward ^ move_backward);
  assign w_tick       = w_count_en & (r_presc == P_MAX);
  assign w_ind_active = enable & (turn_left | turn_right);
  assign w_carry[0]   = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (clear || !enable) begin
      r_presc <= '0;
    end else if (w_count_en) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      bcd_digit u_dig (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (w_carry[gi]),
        .q     (mileage_bcd[gi*BCD_W +: BCD_W]),
        .carry (w_carry[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_moving   <= 1'b0;
    end else begin
      r_moving <= w_count_en;
      if (clear) begin
        r_overflow <= 1'b0;
      end else if (w_carry[DIGITS]) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // LEDs sample the phase before it toggles, so each lit/dark window
  // spans exactly BLINK_DIV edges starting on the first active edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink <= '0;
      r_phase <= 1'b1;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_left  <= enable & turn_left & r_phase;
      r_right <= enable & turn_right & r_phase;
      if (!w_ind_active) begin
        r_blink <= '0;
        r_phase <= 1'b1;
      end else if (r_blink == B_MAX) begin
        r_blink <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_blink <= r_blink + BW'(1);
      end
    end
  end

  assign overflow  = r_overflow;
  assign moving    = r_moving;
  assign left_led  = r_left;
  assign right_led = r_right;

endmodule

// File: tb/tb_mileage_counter.sv
// Directed bench for mileage_counter with a small expected-value queue.
// Runs with TICK_DIV=4, BLINK_DIV=3, DIGITS=2.
module tb_mileage_counter;

  localparam int TD = 4;
  localparam int BD = 3;
  localparam int DG = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear;
  logic          move_forward;
  logic          move_backward;
  logic          turn_left;
  logic          turn_right;
  logic [4*DG-1:0] mileage_bcd;
  logic          overflow;
  logic          moving;
  logic          left_led;
  logic          right_led;

  int n_checks = 0;
  int n_errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  mileage_counter #(
    .TICK_DIV  (TD),
    .BLINK_DIV (BD),
    .DIGITS    (DG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .clear         (clear),
    .move_forward  (move_forward),
    .move_backward (move_backward),
    .turn_left     (turn_left),
    .turn_right    (turn_right),
    .mileage_bcd   (mileage_bcd),
    .overflow      (overflow),
    .moving        (moving),
    .left_led      (left_led),
    .right_led     (right_led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(input int n);
    logic [31:0] r;
    r = '0;
    for (int d = 0; d < DG; d++) begin
      r[d*4 +: 4] = 4'((n / (10 ** d)) % 10);
    end
    return r;
  endfunction

  task automatic expect_v(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %0h expected none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_errors++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled
  // on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  int model_m;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    clear = 1'b0;
    move_forward = 1'b0;
    move_backward = 1'b0;
    turn_left = 1'b0;
    turn_right = 1'b0;
    @(negedge clk);
    expect_v("rst_mileage", 32'h0);
    chk(32'(mileage_bcd));
    expect_v("rst_flags", 32'h0);
    chk({28'h0, overflow, moving, left_led, right_led});
    rst = 1'b0;

    // Forward drive for 12 edges: ticks on edges 4, 8, 12.
    enable = 1'b1;
    move_forward = 1'b1;
    step(1);
    expect_v("t1_moving_e1", 32'h1);
    chk(32'(moving));
    step(2);
    expect_v("t1_mil_e3", to_bcd(0));
    chk(32'(mileage_bcd));
    step(1);
    expect_v("t1_mil_e4", to_bcd(1));
    chk(32'(mileage_bcd));
    step(8);
    expect_v("t1_mil_e12", to_bcd(3));
    chk(32'(mileage_bcd));
    expect_v("t1_moving_e12", 32'h1);
    chk(32'(moving));
    move_forward = 1'b0;
    step(1);
    expect_v("t1_moving_off", 32'h0);
    chk(32'(moving));
    expect_v("t1_mil_hold", to_bcd(3));
    chk(32'(mileage_bcd));

    // Prescaler holds partial distance across idle gaps.
    pulse_clear();
    move_forward = 1'b1;
    step(2);
    move_forward = 1'b0;
    step(5);
    expect_v("t2_mil_idle", to_bcd(0));
    chk(32'(mileage_bcd));
    move_backward = 1'b1;
    step(1);
    expect_v("t2_mil_c3", to_bcd(0));
    chk(32'(mileage_bcd));
    step(1);
    expect_v("t2_mil_c4", to_bcd(1));
    chk(32'(mileage_bcd));
    move_backward = 1'b0;

    // Count up to 99, then wrap.
    pulse_clear();
    move_forward = 1'b1;
    model_m = 0;
    for (int i = 0; i < 99 * TD; i++) begin
      step(1);
      if ((i % TD) == TD - 1) model_m++;
    end
    expect_v("t3_mil_99", to_bcd(model_m));
    chk(32'(mileage_bcd));
    expect_v("t3_ovf_pre", 32'h0);
    chk(32'(overflow));
    step(TD);
    expect_v("t3_mil_wrap", to_bcd(0));
    chk(32'(mileage_bcd));
    expect_v("t3_ovf_set", 32'h1);
    chk(32'(overflow));
    step(TD - 1);
    expect_v("t3_ovf_sticky", 32'h1);
    chk(32'(overflow));
    move_forward = 1'b0;
    pulse_clear();
    expect_v("t3_mil_clr", to_bcd(0));
    chk(32'(mileage_bcd));
    expect_v("t3_ovf_clr", 32'h0);
    chk(32'(overflow));

    // Left indicator: on 3 edges, off 3, on again.
    turn_left = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      expect_v($sformatf("t4_left_e%0d", i + 1),
               32'(((i / BD) % 2) == 0));
      chk(32'(left_led));
      expect_v($sformatf("t4_right_e%0d", i + 1), 32'h0);
      chk(32'(right_led));
    end
    enable = 1'b0;
    step(1);
    expect_v("t4_leds_off", 32'h0);
    chk({30'h0, left_led, right_led});

    // Hazard mode: both LEDs blink together.
    enable = 1'b1;
    turn_right = 1'b1;
    step(1);
    expect_v("t4_haz_e1", 32'h3);
    chk({30'h0, left_led, right_led});
    step(3);
    expect_v("t4_haz_e4", 32'h0);
    chk({30'h0, left_led, right_led});
    turn_left = 1'b0;
    turn_right = 1'b0;

    // Invalid both-direction request adds nothing.
    move_forward = 1'b1;
    step(2 * TD);
    expect_v("t5_mil_pre", to_bcd(2));
    chk(32'(mileage_bcd));
    move_backward = 1'b1;
    step(20);
    expect_v("t5_mil_both", to_bcd(2));
    chk(32'(mileage_bcd));
    expect_v("t5_moving_both", 32'h0);
    chk(32'(moving));
    move_backward = 1'b0;

    // Clear on the tick edge wins and restarts the prescaler.
    step(TD - 1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    expect_v("t5_clr_tick", to_bcd(0));
    chk(32'(mileage_bcd));
    step(TD - 1);
    expect_v("t5_after_clr_3", to_bcd(0));
    chk(32'(mileage_bcd));
    step(1);
    expect_v("t5_after_clr_4", to_bcd(1));
    chk(32'(mileage_bcd));

    // Asynchronous reset mid-operation.
    pulse_clear();
    step(5 * TD - 1);
    turn_left = 1'b1;
    step(1);
    expect_v("t6_mil_5", to_bcd(5));
    chk(32'(mileage_bcd));
    expect_v("t6_pre_flags", 32'h6);
    chk({28'h0, overflow, moving, left_led, right_led});
    #2;
    rst = 1'b1;
    #1;
    expect_v("t6_async_mil", 32'h0);
    chk(32'(mileage_bcd));
    expect_v("t6_async_flags", 32'h0);
    chk({28'h0, overflow, moving, left_led, right_led});
    @(negedge clk);
    rst = 1'b0;
    turn_left = 1'b0;
    step(TD - 1);
    expect_v("t6_restart_3", to_bcd(0));
    chk(32'(mileage_bcd));
    step(1);
    expect_v("t6_restart_4", to_bcd(1));
    chk(32'(mileage_bcd));

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard_left: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
